// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Write-side store queue between the MEM stage and the data-memory port.
//   This block aligns sb/sh/sw stores into a word address, replicated write
//   data and byte enables. It queues them in a DEPTH-entry FIFO and drains
//   them in order over a req/ack handshake. It also forwards still-queued
//   bytes to younger loads through a combinational port. Byte lanes are
//   little-endian.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   st_valid/st_ready   store request from MEM / buffer not full
//   st_addr/st_data     byte address, right-justified store data
//   st_mode             00 byte, 01 half, any other code word
//   st_misalign         current store is misaligned and is rejected
//   mem_req/mem_ack     head entry presented / accepted by memory
//   mem_addr/mem_wdata/mem_be   head entry contents
//   ld_addr             load address checked against the buffer
//   ld_hit/ld_be/ld_data        forwarding result (youngest store wins)
//   empty               buffer holds no entries
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_mode,
  output logic        st_misalign,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [3:0]  ld_be,
  output logic [31:0] ld_data,
  output logic        empty
);

  localparam logic [1:0]     MEM_OP_BYTE = 2'b00;
  localparam logic [1:0]     MEM_OP_HALF = 2'b01;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);

  // Entry storage: word address (bits [31:2]), aligned data, byte enables.
  logic [29:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  be_mem   [DEPTH];

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_misalign;
  logic        push;
  logic        pop;

  // Forwarding only compares word addresses; the byte offset is irrelevant.
  logic ld_addr_lsbs_unused;
  assign ld_addr_lsbs_unused = ^ld_addr[1:0];

  // ---------------------------------------------------------------------------
  // Store alignment
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    al_wdata    = st_data;
    al_be       = 4'b1111;
    al_misalign = 1'b0;
    case (st_mode)
      MEM_OP_BYTE: begin
        al_wdata = {4{st_data[7:0]}};
        al_be    = 4'b0001 << st_addr[1:0];
      end
      MEM_OP_HALF: begin
        al_wdata    = {2{st_data[15:0]}};
        al_be       = st_addr[1] ? 4'b1100 : 4'b0011;
        al_misalign = st_addr[0];
      end
      default: begin
        al_misalign = |st_addr[1:0];
      end
    endcase
  end

  assign st_misalign = st_valid & al_misalign;

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  assign empty    = (count_q == '0);
  assign st_ready = (count_q != CNT_FULL);
  assign mem_req  = ~empty;

  // A misaligned store is dropped regardless of st_ready.
  assign push = st_valid & st_ready & ~al_misalign;
  assign pop  = mem_req & mem_ack;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_ONE;
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
      valid_d[wr_ptr_q] = 1'b1;
    end
    // Push and pop together leave the count unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: the entry payload has no reset. The valid bits and count gate every
  // use of it, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= st_addr[31:2];
      data_mem[wr_ptr_q] <= al_wdata;
      be_mem[wr_ptr_q]   <= al_be;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain port: the head entry is held until it is acked.
  // ---------------------------------------------------------------------------
  assign mem_addr  = {addr_mem[rd_ptr_q], 2'b00};
  assign mem_wdata = data_mem[rd_ptr_q];
  assign mem_be    = be_mem[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Load forwarding
  // The loop walks the entries from oldest (read pointer) to youngest. A
  // younger match therefore overwrites an older one lane by lane. Only
  // registered entries take part, so a store that is being enqueued in the
  // current cycle becomes visible in the next cycle.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] fwd_idx;

  always_comb begin
    ld_data = '0;
    ld_be   = '0;
    fwd_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PTR_W'(k);
      if (valid_q[fwd_idx] && (addr_mem[fwd_idx] == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (be_mem[fwd_idx][b]) begin
            ld_data[8*b +: 8] = data_mem[fwd_idx][8*b +: 8];
            ld_be[b]          = 1'b1;
          end
        end
      end
    end
  end

  assign ld_hit = |ld_be;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Directed, self-checking bench for store_buffer (DEPTH=4). A vector table
//   covers the alignment of each store mode. Hand-written sequences cover the
//   multi-cycle behaviour: full/back-pressure, forwarding merge, simultaneous
//   push/pop with pointer wrap, and reset while draining.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  localparam logic [1:0] M_BYTE = 2'b00;
  localparam logic [1:0] M_HALF = 2'b01;
  localparam logic [1:0] M_WORD = 2'b10;
  localparam logic [1:0] M_WRD3 = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_mode;
  logic        st_misalign;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [3:0]  ld_be;
  logic [31:0] ld_data;
  logic        empty;

  int tests_run = 0;
  int tests_failed = 0;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_mode     (st_mode),
    .st_misalign (st_misalign),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .ld_addr     (ld_addr),
    .ld_hit      (ld_hit),
    .ld_be       (ld_be),
    .ld_data     (ld_data),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] data;
    logic        mis;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] mode, input logic [31:0] addr,
                      input logic [31:0] data, input logic ack);
    st_valid = 1'b1;
    st_mode  = mode;
    st_addr  = addr;
    st_data  = data;
    mem_ack  = ack;
    step();
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    #1;
  endtask

  task automatic ack_once();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    #1;
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] head;

  initial begin
    //          mode    addr          data          mis   exp_addr      exp_wdata     be
    vecs[0] = '{M_BYTE, 32'h0000_1003, 32'h0000_00AB, 1'b0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
    vecs[1] = '{M_BYTE, 32'h0000_1000, 32'h1234_56CD, 1'b0, 32'h0000_1000, 32'hCDCD_CDCD, 4'b0001};
    vecs[2] = '{M_BYTE, 32'h0000_3001, 32'h0000_005A, 1'b0, 32'h0000_3000, 32'h5A5A_5A5A, 4'b0010};
    vecs[3] = '{M_HALF, 32'h0000_2002, 32'hFFFF_8765, 1'b0, 32'h0000_2000, 32'h8765_8765, 4'b1100};
    vecs[4] = '{M_HALF, 32'h0000_2000, 32'h0000_4321, 1'b0, 32'h0000_2000, 32'h4321_4321, 4'b0011};
    vecs[5] = '{M_WRD3, 32'h0000_3004, 32'hDEAD_BEEF, 1'b0, 32'h0000_3004, 32'hDEAD_BEEF, 4'b1111};
    vecs[6] = '{M_HALF, 32'h0000_3001, 32'h0000_1111, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[7] = '{M_WORD, 32'h0000_3002, 32'h2222_2222, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[8] = '{M_WRD3, 32'h0000_3001, 32'h3333_3333, 1'b1, 32'h0,         32'h0,         4'b0000};

    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_mode  = M_BYTE;
    mem_ack  = 1'b0;
    ld_addr  = '0;

    // Reset state.
    #12;
    check("rst mem_req",     32'(mem_req),     32'd0);
    check("rst empty",       32'(empty),       32'd1);
    check("rst st_ready",    32'(st_ready),    32'd1);
    check("rst ld_hit",      32'(ld_hit),      32'd0);
    check("rst ld_be",       32'(ld_be),       32'd0);
    check("rst ld_data",     ld_data,          32'd0);
    check("rst st_misalign", 32'(st_misalign), 32'd0);
    rst_n = 1'b1;
    step();

    // Alignment table: enqueue each store, inspect the head, then drain it.
    for (int i = 0; i < 9; i++) begin
      st_valid = 1'b1;
      st_mode  = vecs[i].mode;
      st_addr  = vecs[i].addr;
      st_data  = vecs[i].data;
      #1;
      check($sformatf("vec%0d st_misalign", i), 32'(st_misalign), 32'(vecs[i].mis));
      step();
      st_valid = 1'b0;
      #1;
      if (vecs[i].mis) begin
        check($sformatf("vec%0d mem_req", i), 32'(mem_req), 32'd0);
        check($sformatf("vec%0d empty", i),   32'(empty),   32'd1);
      end else begin
        check($sformatf("vec%0d mem_req", i),   32'(mem_req), 32'd1);
        check($sformatf("vec%0d empty", i),     32'(empty),   32'd0);
        check($sformatf("vec%0d mem_addr", i),  mem_addr,     vecs[i].exp_addr);
        check($sformatf("vec%0d mem_wdata", i), mem_wdata,    vecs[i].exp_wdata);
        check($sformatf("vec%0d mem_be", i),    32'(mem_be),  32'(vecs[i].exp_be));
        ack_once();
        check($sformatf("vec%0d drained", i),   32'(empty),   32'd1);
      end
    end

    // Fill to full with mem_ack held low, then hold a 5th store.
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill%0d st_ready", i), 32'(st_ready), 32'd1);
      push(M_WORD, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
    end
    check("full st_ready", 32'(st_ready), 32'd0);
    st_valid = 1'b1;
    st_mode  = M_WORD;
    st_addr  = 32'h20;
    st_data  = 32'hBAD0_BAD0;
    step();
    st_valid = 1'b0;
    #1;
    check("held st_ready", 32'(st_ready), 32'd0);
    check("held head",     mem_addr,      32'h10);
    ack_once();
    check("pop1 st_ready", 32'(st_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("drain%0d addr", i),  mem_addr,  32'h10 + 32'(4 * i));
      check($sformatf("drain%0d wdata", i), mem_wdata, 32'hA000_0000 + 32'(i));
      ack_once();
    end
    check("drain empty", 32'(empty), 32'd1);

    // Forwarding merge: sw then sb to the same word; the younger byte wins.
    push(M_WORD, 32'h2000, 32'h1122_3344, 1'b0);
    ld_addr  = 32'h2002;
    st_valid = 1'b1;
    st_mode  = M_BYTE;
    st_addr  = 32'h2001;
    st_data  = 32'h0000_0055;
    #1;
    check("fwd pre-enq data", ld_data, 32'h1122_3344);
    step();
    st_valid = 1'b0;
    #1;
    check("fwd ld_hit",  32'(ld_hit), 32'd1);
    check("fwd ld_be",   32'(ld_be),  32'hF);
    check("fwd ld_data", ld_data,     32'h1122_5544);
    ld_addr = 32'h2004;
    #1;
    check("fwd miss hit",  32'(ld_hit), 32'd0);
    check("fwd miss data", ld_data,     32'd0);
    // The head that is being acked still forwards in this cycle.
    ld_addr = 32'h2000;
    mem_ack = 1'b1;
    #1;
    check("fwd acked head", ld_data, 32'h1122_5544);
    step();
    mem_ack = 1'b0;
    #1;
    check("fwd after pop be",   32'(ld_be), 32'b0010);
    check("fwd after pop data", ld_data,    32'h0000_5500);
    ack_once();
    check("fwd empty", 32'(empty), 32'd1);
    ld_addr = '0;

    // Simultaneous push and pop at count 2, repeated past DEPTH for wrap.
    exp_q.delete();
    push(M_WORD, 32'h30, 32'h30, 1'b0); exp_q.push_back(32'h30);
    push(M_WORD, 32'h34, 32'h34, 1'b0); exp_q.push_back(32'h34);
    for (int i = 0; i < 6; i++) begin
      head = exp_q.pop_front();
      check($sformatf("sim%0d head", i),  mem_addr,  head);
      check($sformatf("sim%0d wdata", i), mem_wdata, head);
      push(M_WORD, 32'h40 + 32'(4 * i), 32'h40 + 32'(4 * i), 1'b1);
      exp_q.push_back(32'h40 + 32'(4 * i));
      check($sformatf("sim%0d st_ready", i), 32'(st_ready), 32'd1);
    end
    for (int i = 0; i < 2; i++) begin
      head = exp_q.pop_front();
      check($sformatf("simdrain%0d addr", i), mem_addr, head);
      check($sformatf("simdrain%0d req", i),  32'(mem_req), 32'd1);
      ack_once();
    end
    check("sim count kept", 32'(empty), 32'd1);

    // Asynchronous reset while draining three entries.
    push(M_WORD, 32'h60, 32'h60, 1'b0);
    push(M_WORD, 32'h64, 32'h64, 1'b0);
    push(M_WORD, 32'h68, 32'h68, 1'b0);
    check("prerst mem_req", 32'(mem_req), 32'd1);
    ld_addr = 32'h64;
    mem_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst mem_req",  32'(mem_req),  32'd0);
    check("midrst empty",    32'(empty),    32'd1);
    check("midrst st_ready", 32'(st_ready), 32'd1);
    check("midrst ld_hit",   32'(ld_hit),   32'd0);
    mem_ack = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    push(M_BYTE, 32'h71, 32'h77, 1'b0);
    check("postrst addr",  mem_addr,     32'h70);
    check("postrst be",    32'(mem_be),  32'b0010);
    check("postrst wdata", mem_wdata,    32'h7777_7777);
    ack_once();
    check("postrst empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
